mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers, multi-cycle mult/div
// sequencing with a busy down-counter, pipeline stall and MFHI/MFLO read port.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state  | meaning
    // S_IDLE | ready to accept an issue
    // S_BUSY | mult/div in flight, cnt counts down to commit

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic            issue;
    logic            div_ovf;
    logic signed [63:0] mul_s;
    logic [63:0]     mul_u;
    logic signed [31:0] sa, sb, quot_s, rem_s;
    logic [31:0]     bu, quot_u, rem_u;
    logic [31:0]     res_hi, res_lo;

    assign issue = (state_q == S_IDLE) && start && !req
                   && (mdop >= OP_MULT) && (mdop <= OP_MTLO);

    assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign mul_u = {32'd0, a} * {32'd0, b};

    // Divisor is forced to 1 for /0 and for MIN/-1; the latter then yields
    // exactly quotient=MIN, remainder=0, and no division ever overflows.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sa      = a;
    assign sb      = ((b == 32'd0) || div_ovf) ? 32'sd1 : b;
    assign quot_s  = sa / sb;
    assign rem_s   = sa % sb;
    assign bu      = (b == 32'd0) ? 32'd1 : b;
    assign quot_u  = a / bu;
    assign rem_u   = a % bu;

    // Divide by zero latches the current HI/LO so the commit is a no-op.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (mdop)
            OP_MULT:  {res_hi, res_lo} = mul_s;
            OP_MULTU: {res_hi, res_lo} = mul_u;
            OP_DIV: begin
                if (b != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    case (mdop)
                        OP_MULT, OP_MULTU: begin
                            hi_tmp_d = res_hi;
                            lo_tmp_d = res_lo;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_tmp_d = res_hi;
                            lo_tmp_d = res_lo;
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = S_BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign busy  = (state_q == S_BUSY);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = (busy || (start && (mdop >= OP_MULT) && (mdop <= OP_DIVU)))
                   && (mdop >= OP_MULT) && (mdop <= OP_MFLO);
    assign rdata = (mdop == OP_MFHI) ? hi_q :
                   (mdop == OP_MFLO) ? lo_q : 32'd0;

endmodule
